// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter/framer sharing one byte UART transmitter among N_REQ requesters.
// Optional header byte enabled by defining TX_FRAME_HDR_EN.
module tx_frame_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [N_REQ-1:0]   REQ_En,
    input  logic [40*N_REQ-1:0] REQ_Data,
    output logic [N_REQ-1:0]   REQ_Done,
    input  logic               TX_Done_Sig,
    output logic               TX_En_Sig,
    output logic [7:0]         TX_Data,
    output logic               Busy,
    output logic [2:0]         Grant_Id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

`ifdef TX_FRAME_HDR_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    state_t                 state_q, state_d;
    logic [2:0]             last_q, last_d;
    logic [2:0]             grant_q, grant_d;
    logic [39:0]            shadow_q, shadow_d;
    logic [7:0]             acc_q, acc_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   tx_en_q, tx_en_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   found_s;
    logic [2:0]             gnt_s;
    logic [39:0]            pay_s;
    logic [7:0]             byte_s;

    function automatic logic [7:0] chk_byte(input logic [7:0] acc);
        return ~acc + 8'd1;
    endfunction

    function automatic logic [7:0] pay_byte(input logic [39:0] p, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = p[39:32];
            3'd1:    b = p[31:24];
            3'd2:    b = p[23:16];
            3'd3:    b = p[15:8];
            3'd4:    b = p[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // base is at most N_REQ-1 and k at most N_REQ, so one subtraction wraps it
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return 3'(s);
    endfunction

    // Round-robin search starting after the last served requester, plus payload select
    always_comb begin
        found_s = 1'b0;
        gnt_s   = 3'd0;
        pay_s   = 40'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found_s && REQ_En[i] && (wrap_idx(last_q, k) == 3'(i))) begin
                    found_s = 1'b1;
                    gnt_s   = 3'(i);
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_s == 3'(i)) begin
                pay_s = REQ_Data[40*i +: 40];
            end
        end
    end

    // Frame byte for the current count; the checksum is always the final byte
    always_comb begin
        byte_s = 8'h00;
        if (cnt_q == LAST_IDX) begin
            byte_s = chk_byte(acc_q);
        end else begin
`ifdef TX_FRAME_HDR_EN
            if (cnt_q == 3'd0) begin
                byte_s = {5'b10100, grant_q};
            end else begin
                byte_s = pay_byte(shadow_q, cnt_q - 3'd1);
            end
`else
            byte_s = pay_byte(shadow_q, cnt_q);
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        shadow_d  = shadow_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        done_d    = {N_REQ{1'b0}};
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                tx_en_d = 1'b0;
                if (found_s) begin
                    state_d  = ST_LOAD;
                    grant_d  = gnt_s;
                    shadow_d = pay_s;
                    busy_d   = 1'b1;
                    acc_d    = 8'h00;
                    cnt_d    = 3'd0;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                tx_data_d = byte_s;
                tx_en_d   = 1'b1;
                state_d   = ST_SEND;
                if (cnt_q != LAST_IDX) begin
                    acc_d = acc_q + byte_s;
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_SEND: begin
                if (TX_Done_Sig) begin
                    tx_en_d = 1'b0;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        for (int i = 0; i < N_REQ; i++) begin
                            done_d[i] = (grant_q == 3'(i));
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    tx_en_d = 1'b1;
                end
            end
            ST_DONE: begin
                last_d  = grant_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            last_q    <= 3'(N_REQ - 1);
            grant_q   <= 3'd0;
            shadow_q  <= 40'd0;
            acc_q     <= 8'h00;
            cnt_q     <= 3'd0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            done_q    <= {N_REQ{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            shadow_q  <= shadow_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign REQ_Done  = done_q;
    assign TX_En_Sig = tx_en_q;
    assign TX_Data   = tx_data_q;
    assign Busy      = busy_q;
    assign Grant_Id  = grant_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: stimulus pushes expected bytes/grants, monitor pops.
module tb_tx_frame_arbiter;
    localparam int N = 4;
`ifdef TX_FRAME_HDR_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 6;
`endif

    logic            CLK = 1'b0;
    logic            RSTn;
    logic [N-1:0]    REQ_En;
    logic [40*N-1:0] REQ_Data;
    logic [N-1:0]    REQ_Done;
    logic            TX_Done_Sig;
    logic            TX_En_Sig;
    logic [7:0]      TX_Data;
    logic            Busy;
    logic [2:0]      Grant_Id;

    int checks = 0;
    int errors = 0;
    int bytes_seen = 0;
    bit noise_en = 1'b0;

    logic [7:0]   exp_byte_q[$];
    logic [N-1:0] exp_done_q[$];
    logic [2:0]   exp_id_q[$];

    tx_frame_arbiter #(.N_REQ(N)) dut (
        .CLK(CLK), .RSTn(RSTn), .REQ_En(REQ_En), .REQ_Data(REQ_Data),
        .REQ_Done(REQ_Done), .TX_Done_Sig(TX_Done_Sig), .TX_En_Sig(TX_En_Sig),
        .TX_Data(TX_Data), .Busy(Busy), .Grant_Id(Grant_Id)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int id, input logic [39:0] p);
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'h00;
`ifdef TX_FRAME_HDR_EN
        b = {5'b10100, 3'(id)};
        exp_byte_q.push_back(b);
        sum = sum + b;
`endif
        for (int k = 0; k < 5; k++) begin
            b = p[39-8*k -: 8];
            exp_byte_q.push_back(b);
            sum = sum + b;
        end
        exp_byte_q.push_back(8'h00 - sum);
        exp_done_q.push_back(N'(1) << id);
        exp_id_q.push_back(3'(id));
    endtask

    task automatic push_hand(input int id, input logic [55:0] bytes);
        for (int k = 0; k < FLEN; k++) begin
            exp_byte_q.push_back(bytes[8*(FLEN-1-k) +: 8]);
        end
        exp_done_q.push_back(N'(1) << id);
        exp_id_q.push_back(3'(id));
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_en", 40'(TX_En_Sig), 40'd0);
        check("rst_tx_data", 40'(TX_Data), 40'd0);
        check("rst_req_done", 40'(REQ_Done), 40'd0);
        check("rst_busy", 40'(Busy), 40'd0);
        check("rst_grant_id", 40'(Grant_Id), 40'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        REQ_En = '0;
        repeat (2) @(negedge CLK);
        check_reset_outputs();
        RSTn = 1'b1;
    endtask

    task automatic run_until_done(input int n, input logic [N-1:0] drop);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
            if (|REQ_Done) begin
                got++;
                REQ_En = REQ_En & ~(REQ_Done & drop);
            end
        end
        check("frames_completed", 40'(got), 40'(n));
    endtask

    // Byte sink: acknowledges each byte 3 cycles after enable rises; optional Done noise outside SEND
    initial begin
        int cnt;
        cnt = 0;
        TX_Done_Sig = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_Done_Sig) begin
                TX_Done_Sig = 1'b0;
            end else if (TX_En_Sig) begin
                if (cnt == 2) begin
                    TX_Done_Sig = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (noise_en) TX_Done_Sig = 1'b1;
            end
        end
    end

    // Monitor: each enable rise presents a new byte; each REQ_Done pulse ends a frame
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_En_Sig && !prev_en) begin
                bytes_seen++;
                if (exp_byte_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%h expected=none", TX_Data);
                end else begin
                    check("tx_byte", 40'(TX_Data), 40'(exp_byte_q.pop_front()));
                end
            end
            prev_en = TX_En_Sig;
            if (REQ_Done != '0) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%b expected=none", REQ_Done);
                end else begin
                    check("req_done", 40'(REQ_Done), 40'(exp_done_q.pop_front()));
                    check("grant_id", 40'(Grant_Id), 40'(exp_id_q.pop_front()));
                    check("busy_at_done", 40'(Busy), 40'd1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        RSTn = 1'b0;
        REQ_En = '0;
        REQ_Data = '0;
        #1;
        check_reset_outputs();
        do_reset();

        // single frame, hand-computed bytes
        REQ_Data[39:0] = 40'h0102030405;
`ifdef TX_FRAME_HDR_EN
        push_hand(0, 56'hA0_01_02_03_04_05_51);
`else
        push_hand(0, 56'h00_01_02_03_04_05_F1);
`endif
        REQ_En = 4'b0001;
        run_until_done(1, 4'b1111);

        // four simultaneous requests: served 0,1,2,3
        do_reset();
        REQ_Data = {40'h4444444444, 40'h3333333333, 40'h2222222222, 40'h1111111111};
        for (int i = 0; i < N; i++) push_frame(i, REQ_Data[40*i +: 40]);
        REQ_En = 4'b1111;
        run_until_done(4, 4'b1111);

        // 0 and 2 keep requesting: grants alternate
        do_reset();
        REQ_Data = {40'h0, 40'hC0FFEE0102, 40'h0, 40'h8080808080};
        for (int f = 0; f < 8; f++) begin
            if (f % 2 == 0) push_frame(0, 40'h8080808080);
            else            push_frame(2, 40'hC0FFEE0102);
        end
        REQ_En = 4'b0101;
        run_until_done(8, 4'b0000);
        REQ_En = '0;

        // all-ones payload, data changed right after grant
        do_reset();
        REQ_Data[39:0] = 40'hFFFFFFFFFF;
`ifdef TX_FRAME_HDR_EN
        push_hand(0, 56'hA0_FF_FF_FF_FF_FF_65);
`else
        push_hand(0, 56'h00_FF_FF_FF_FF_FF_05);
`endif
        REQ_En = 4'b0001;
        cyc = 0;
        while (!Busy && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check("busy_after_grant", 40'(Busy), 40'd1);
        @(negedge CLK);
        REQ_Data[39:0] = 40'h0000000000;
        run_until_done(1, 4'b1111);

        // reset during byte 3 aborts; frame restarts from byte 1
        do_reset();
        REQ_Data[39:0] = 40'h1122334455;
        push_frame(0, 40'h1122334455);
        REQ_En = 4'b0001;
        base = bytes_seen;
        cyc = 0;
        while (bytes_seen < base + 3 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("reached_byte3", 40'(bytes_seen - base), 40'd3);
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check_reset_outputs();
        exp_byte_q.delete();
        exp_done_q.delete();
        exp_id_q.delete();
        @(negedge CLK);
        RSTn = 1'b1;
        push_frame(0, 40'h1122334455);
        run_until_done(1, 4'b1111);

        // Done noise in IDLE/LOAD must be ignored
        do_reset();
        noise_en = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            check("noise_idle_busy", 40'(Busy), 40'd0);
            check("noise_idle_en", 40'(TX_En_Sig), 40'd0);
        end
        REQ_Data[79:40] = 40'hA5A55A5A00;
        push_frame(1, 40'hA5A55A5A00);
        REQ_En = 4'b0010;
        run_until_done(1, 4'b1111);
        noise_en = 1'b0;

        repeat (5) @(negedge CLK);
        check("queues_empty", 40'(exp_byte_q.size() + exp_done_q.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
